// File: rtl/byte_sram.sv
// Flop-based single-port word memory with a registered read port.
// Reset clears every word and the read register; simultaneous read/write is write-first.
module byte_sram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              sram_clk,
    input  logic              sram_ares,
    input  logic              wr_enable,
    input  logic              rd_enable,
    input  logic [ADDR_W-1:0] ram_index,
    input  logic [DATA_W-1:0] sram_data_in,
    output logic [DATA_W-1:0] sram_data_out
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    always_comb begin
        mem_d     = mem_q;
        rd_data_d = rd_data_q;
        if (wr_enable) begin
            mem_d[ram_index] = sram_data_in;
        end
        // A read in the same cycle as a write to that word returns the new data.
        if (rd_enable) begin
            rd_data_d = wr_enable ? sram_data_in : mem_q[ram_index];
        end
    end

    always_ff @(posedge sram_clk or negedge sram_ares) begin
        if (!sram_ares) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign sram_data_out = rd_data_q;

endmodule

// File: tb/tb_byte_sram.sv
// Self-checking bench for byte_sram: directed corner cases, randomized traffic
// against an array model, and repeated asynchronous reset pulses.
module tb_byte_sram;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  // clock / reset
  logic sram_clk = 1'b0;
  always #5 sram_clk = ~sram_clk;

  logic              sram_ares;
  logic              wr_enable;
  logic              rd_enable;
  logic [ADDR_W-1:0] ram_index;
  logic [DATA_W-1:0] sram_data_in;
  logic [DATA_W-1:0] sram_data_out;

  byte_sram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .sram_clk     (sram_clk),
    .sram_ares    (sram_ares),
    .wr_enable    (wr_enable),
    .rd_enable    (rd_enable),
    .ram_index    (ram_index),
    .sram_data_in (sram_data_in),
    .sram_data_out(sram_data_out)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] model_out;
  logic [DATA_W-1:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%02h expected=%02h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_out = '0;
  endtask

  // driver: one access per clock, checked 1 time unit after the edge
  task automatic do_op(input bit we, input bit re, input logic [ADDR_W-1:0] idx,
                       input logic [DATA_W-1:0] data, input string tag);
    @(negedge sram_clk);
    wr_enable    = we;
    rd_enable    = re;
    ram_index    = idx;
    sram_data_in = data;
    @(posedge sram_clk);
    if (we) model_mem[idx] = data;
    if (re) model_out = model_mem[idx];
    exp_q.push_back(model_out);
    #1;
    check_eq(tag, sram_data_out, exp_q.pop_front());
  endtask

  // asynchronous reset pulse taken between clock edges, with enables active
  task automatic reset_pulse(input string tag);
    @(negedge sram_clk);
    #2;
    wr_enable    = 1'b1;
    rd_enable    = 1'b1;
    ram_index    = 7'h05;
    sram_data_in = 8'hFF;
    sram_ares    = 1'b0;
    #1;
    model_clear();
    check_eq({tag, "_async"}, sram_data_out, model_out);
    repeat (2) @(posedge sram_clk);
    #1;
    check_eq({tag, "_held"}, sram_data_out, model_out);
    @(negedge sram_clk);
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    sram_ares = 1'b1;
  endtask

  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_dat;

  initial begin
    sram_ares    = 1'b1;
    wr_enable    = 1'b0;
    rd_enable    = 1'b0;
    ram_index    = '0;
    sram_data_in = '0;
    model_clear();

    // reset with no clock edge yet
    #2;
    sram_ares = 1'b0;
    #1;
    check_eq("reset_no_clock", sram_data_out, 8'h00);
    @(negedge sram_clk);
    sram_ares = 1'b1;

    do_op(0, 1, 7'h33, 8'h00, "rd_after_reset_33");
    do_op(0, 1, 7'h7F, 8'h00, "rd_after_reset_7f");

    do_op(1, 0, 7'h05, 8'hA5, "wr_05_hold");
    do_op(0, 1, 7'h05, 8'h00, "rd_05");

    do_op(1, 0, 7'h00, 8'h11, "wr_00");
    do_op(1, 0, 7'h7F, 8'hEE, "wr_7f");
    do_op(0, 1, 7'h00, 8'h00, "rd_00");
    do_op(0, 1, 7'h7F, 8'h00, "rd_7f");
    do_op(0, 1, 7'h01, 8'h00, "rd_01_no_alias");

    do_op(1, 1, 7'h10, 8'h3C, "wr_rd_same_edge");
    do_op(0, 1, 7'h10, 8'h00, "rd_10_after_both");

    do_op(0, 1, 7'h05, 8'h00, "rd_05_again");
    do_op(1, 0, 7'h05, 8'h5A, "wr_05_out_holds");
    do_op(0, 0, 7'h05, 8'h00, "idle_out_holds");
    do_op(0, 1, 7'h05, 8'h00, "rd_05_new");

    // randomized traffic, biased toward a few indices to force reuse
    for (int n = 0; n < 400; n++) begin
      r_idx = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, DEPTH - 1))
                                          : ADDR_W'($urandom_range(0, 7));
      r_dat = DATA_W'($urandom);
      do_op(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), r_idx, r_dat, "random");
    end

    reset_pulse("reset_mid");
    do_op(0, 1, 7'h05, 8'h00, "rd_05_after_reset");
    do_op(0, 1, 7'h10, 8'h00, "rd_10_after_reset");
    for (int i = 0; i < DEPTH; i++) begin
      do_op(0, 1, ADDR_W'(i), 8'h00, "sweep_after_reset");
    end

    // fill again, then confirm a second reset gives the same clean state
    for (int i = 0; i < DEPTH; i++) begin
      do_op(1, ($urandom_range(0, 1) == 1), ADDR_W'(i), DATA_W'($urandom), "fill");
    end
    do_op(0, 1, 7'h7F, 8'h00, "rd_7f_filled");
    reset_pulse("reset_again");
    for (int i = 0; i < DEPTH; i += 9) begin
      do_op(0, 1, ADDR_W'(i), 8'h00, "sweep_after_reset2");
    end
    do_op(1, 1, 7'h7F, 8'h99, "wr_rd_after_reset2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
